// File: rtl/rtc_save_pkg.sv
// Shared definitions for the HuC3 RTC save-file path: FSM states, word geometry
// and the word-index-to-field mapping used by this sequencer and the bridge.
package rtc_save_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT,
        ST_SNAP,
        ST_SAVE,
        ST_FINISH
    } rtc_state_t;

    localparam int RTC_WORDS       = 5;
    localparam int RTC_COMMIT_ADDR = 5;
    localparam int RTC_WORD_W      = 16;
    localparam int RTC_SHADOW_W    = RTC_WORDS * RTC_WORD_W;

    // Shadow layout is {savedtime[47:0], timestamp[31:0]}, so word k is the
    // k-th 16-bit slice counting up from the timestamp low half.
    function automatic logic [RTC_WORD_W-1:0] rtc_word(
        input logic [RTC_SHADOW_W-1:0] shadow,
        input logic [2:0]              idx
    );
        logic [RTC_WORD_W-1:0] w;
        case (idx)
            3'd0:    w = shadow[15:0];
            3'd1:    w = shadow[31:16];
            3'd2:    w = shadow[47:32];
            3'd3:    w = shadow[63:48];
            3'd4:    w = shadow[79:64];
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rtc_save_io.sv
// Save-file sequencer for the HuC3 RTC: replays five words from the bridge into
// the mapper backup port on load, and streams a coherent snapshot out on save.
module rtc_save_io
    import rtc_save_pkg::*;
#(
    parameter int TIMEOUT_W = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        load_req,
    input  logic        save_req,
    input  logic [15:0] ld_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    output logic [15:0] sv_data,
    output logic [2:0]  sv_addr,
    output logic        sv_valid,
    input  logic        sv_ready,
    input  logic [31:0] RTC_timestampOut,
    input  logic [47:0] RTC_savedtimeOut,
    input  logic        RTC_inuse,
    output logic        bk_rtc_wr,
    output logic [16:0] bk_addr,
    output logic [15:0] bk_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] LAST_IDX   = 3'(RTC_WORDS - 1);
    localparam logic [2:0] COMMIT_IDX = 3'(RTC_COMMIT_ADDR);

    rtc_state_t state, state_next;

    logic                    load_pend, save_pend;
    logic [2:0]              cnt;
    logic [RTC_SHADOW_W-1:0] shadow;
    logic [TIMEOUT_W-1:0]    timeout;
    logic                    err_q, wr_q, done_q;
    logic [2:0]              addr_q;
    logic [RTC_WORD_W-1:0]   data_q;
    logic                    load_go, save_go, ld_hs, sv_hs;

    // A request pulse counts as pending in the same cycle it arrives, so IDLE
    // can leave on the very next edge.
    assign load_go = load_pend | load_req;
    assign save_go = save_pend | save_req;

    assign ld_ready = enable & (state == ST_LOAD);
    assign sv_valid = enable & (state == ST_SAVE);
    assign ld_hs    = ld_ready & ld_valid;
    assign sv_hs    = sv_valid & sv_ready;

    // Save-side outputs are quiet outside SAVE; while stalled cnt and shadow
    // do not move, which keeps address and data stable.
    assign sv_addr = sv_valid ? cnt : 3'd0;
    assign sv_data = sv_valid ? rtc_word(shadow, cnt) : '0;

    assign bk_rtc_wr = wr_q & enable;
    assign bk_addr   = {14'd0, addr_q};
    assign bk_data   = data_q;
    assign done      = done_q & enable;
    assign err       = err_q;
    assign busy      = (state != ST_IDLE) | done_q;

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state logic; dropping enable forces IDLE from anywhere.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_go)      state_next = ST_LOAD;
                    else if (save_go) state_next = ST_SNAP;
                end
                ST_LOAD: begin
                    if (ld_hs) begin
                        if (cnt == LAST_IDX) state_next = ST_COMMIT;
                    end else if (timeout == '1) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_COMMIT: state_next = ST_FINISH;
                ST_SNAP:   state_next = ST_SAVE;
                ST_SAVE: begin
                    if (sv_hs && cnt == LAST_IDX) state_next = ST_FINISH;
                end
                ST_FINISH: state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // Datapath: pending requests, shared word counter, stall timer, snapshot
    // shadow and the registered mapper write port.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            load_pend <= 1'b0;
            save_pend <= 1'b0;
            cnt       <= '0;
            shadow    <= '0;
            timeout   <= '0;
            err_q     <= 1'b0;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else if (!enable) begin
            load_pend <= 1'b0;
            save_pend <= 1'b0;
            cnt       <= '0;
            shadow    <= '0;
            timeout   <= '0;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            load_pend <= load_pend | load_req;
            save_pend <= save_pend | save_req;
            case (state)
                ST_IDLE: begin
                    if (load_go) begin
                        load_pend <= 1'b0;
                        cnt       <= '0;
                        timeout   <= '0;
                        err_q     <= 1'b0;
                    end else if (save_go) begin
                        save_pend <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (ld_hs) begin
                        wr_q    <= 1'b1;
                        addr_q  <= cnt;
                        data_q  <= ld_data;
                        timeout <= '0;
                        cnt     <= (cnt == LAST_IDX) ? 3'd0 : cnt + 3'd1;
                    end else if (timeout == '1) begin
                        err_q   <= 1'b1;
                        timeout <= '0;
                        cnt     <= '0;
                    end else begin
                        timeout <= timeout + TIMEOUT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    wr_q   <= 1'b1;
                    addr_q <= COMMIT_IDX;
                    data_q <= '0;
                end
                ST_SNAP: begin
                    shadow <= RTC_inuse ? {RTC_savedtimeOut, RTC_timestampOut} : '0;
                    cnt    <= '0;
                end
                ST_SAVE: begin
                    if (sv_hs) cnt <= (cnt == LAST_IDX) ? 3'd0 : cnt + 3'd1;
                end
                ST_FINISH: done_q <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_save_io.sv
// Scoreboard bench for rtc_save_io: directed load/save vectors push expected
// mapper writes, save words and done pulses; a negedge monitor pops and checks.
module tb_rtc_save_io;
    import rtc_save_pkg::*;

    localparam int TB_TW = 6;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        load_req = 1'b0;
    logic        save_req = 1'b0;
    logic [15:0] ld_data = '0;
    logic        ld_valid = 1'b0;
    logic        sv_ready = 1'b0;
    logic [31:0] ts = '0;
    logic [47:0] st = '0;
    logic        inuse = 1'b0;
    logic        ld_ready, sv_valid, bk_rtc_wr, busy, done, err;
    logic [15:0] sv_data, bk_data;
    logic [2:0]  sv_addr;
    logic [16:0] bk_addr;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
    } word_t;

    word_t       bk_q[$];
    word_t       sv_q[$];
    word_t       mon_e;
    int          exp_done = 0;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          bk_cyc[8];
    int          sv_cyc[8];
    int          last_done_cyc = 0;
    int          last_hs_cyc = 0;
    int          req_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [2:0]  prev_addr = '0;
    logic [15:0] prev_data = '0;
    logic [15:0] ld_words[5];
    logic [15:0] sv_words[5];

    rtc_save_io #(.TIMEOUT_W(TB_TW)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable),
        .load_req(load_req), .save_req(save_req),
        .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .sv_data(sv_data), .sv_addr(sv_addr), .sv_valid(sv_valid), .sv_ready(sv_ready),
        .RTC_timestampOut(ts), .RTC_savedtimeOut(st), .RTC_inuse(inuse),
        .bk_rtc_wr(bk_rtc_wr), .bk_addr(bk_addr), .bk_data(bk_data),
        .busy(busy), .done(done), .err(err)
    );

    // Free-running clock and cycle counter.
    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop expected mapper writes, save words and done pulses; also
    // verify save outputs hold steady across a stall.
    always @(negedge clk_sys) begin
        if (bk_rtc_wr) begin
            bk_cyc[bk_addr[2:0]] = cyc;
            if (bk_q.size() == 0) begin
                checkOutput("bk_unexpected_strobe_addr", 80'(bk_addr), 80'hFFFF);
            end else begin
                mon_e = bk_q.pop_front();
                checkOutput("bk_addr", 80'(bk_addr), 80'(mon_e.addr));
                checkOutput("bk_data", 80'(bk_data), 80'(mon_e.data));
            end
        end
        if (sv_valid && sv_ready) begin
            sv_cyc[sv_addr] = cyc;
            if (sv_q.size() == 0) begin
                checkOutput("sv_unexpected_word_addr", 80'(sv_addr), 80'hFFFF);
            end else begin
                mon_e = sv_q.pop_front();
                checkOutput("sv_addr", 80'(sv_addr), 80'(mon_e.addr));
                checkOutput("sv_data", 80'(sv_data), 80'(mon_e.data));
            end
        end
        if (prev_stall && sv_valid) begin
            checkOutput("sv_addr_stable", 80'(sv_addr), 80'(prev_addr));
            checkOutput("sv_data_stable", 80'(sv_data), 80'(prev_data));
        end
        prev_stall = sv_valid && !sv_ready;
        prev_addr  = sv_addr;
        prev_data  = sv_data;
        if (done) begin
            last_done_cyc = cyc;
            if (exp_done == 0) checkOutput("done_unexpected", 80'd1, 80'd0);
            else exp_done--;
        end
    end

    task automatic applyStimulus(input logic do_load, input logic do_save);
        load_req = do_load;
        save_req = do_save;
        @(posedge clk_sys); #1;
        load_req = 1'b0;
        save_req = 1'b0;
    endtask

    task automatic pushLoad(input int n, input bit full);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w.addr = 3'(i);
            w.data = ld_words[i];
            bk_q.push_back(w);
        end
        if (full) begin
            w.addr = 3'd5;
            w.data = 16'h0000;
            bk_q.push_back(w);
            exp_done++;
        end
    endtask

    task automatic pushSave(input int n, input bit full);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w.addr = 3'(i);
            w.data = sv_words[i];
            sv_q.push_back(w);
        end
        if (full) exp_done++;
    endtask

    // Offer words 0..n-1 back to back, then drop valid.
    task automatic loadWords(input int n);
        int   i = 0;
        int   guard = 0;
        int   hs_cyc;
        logic hs;
        ld_valid = 1'b1;
        ld_data  = ld_words[0];
        while (i < n && guard < 100) begin
            @(negedge clk_sys);
            hs = ld_ready && ld_valid;
            hs_cyc = cyc;
            @(posedge clk_sys); #1;
            guard++;
            if (hs) begin
                i++;
                last_hs_cyc = hs_cyc;
                if (i < n) ld_data = ld_words[i];
            end
        end
        ld_valid = 1'b0;
        if (i < n) checkOutput("load_words_accepted", 80'(i), 80'(n));
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while (exp_done != 0 && n < budget) begin
            @(posedge clk_sys); #1;
            n++;
        end
        if (exp_done != 0) begin
            checkOutput(name, 80'(exp_done), 80'd0);
            exp_done = 0;
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        int n;
        enable = 1'b1;
        inuse  = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        checkOutput("reset_outputs",
            80'({ld_ready, sv_valid, sv_addr, sv_data, bk_rtc_wr, bk_addr, bk_data, busy, done, err}), 80'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;

        // Full load, continuous valid.
        ld_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0005};
        pushLoad(5, 1);
        ld_valid = 1'b1;
        ld_data  = ld_words[0];
        req_cyc  = cyc;
        applyStimulus(1'b1, 1'b0);
        checkOutput("load_ready_next_cycle", 80'(ld_ready), 80'd1);
        checkOutput("load_busy", 80'(busy), 80'd1);
        loadWords(5);
        waitDone("load_done_timeout", 20);
        checkOutput("load_latency", 80'(last_done_cyc - req_cyc), 80'd8);
        checkOutput("load_first_strobe", 80'(bk_cyc[0] - req_cyc), 80'd2);
        checkOutput("commit_after_word4", 80'(bk_cyc[5] - bk_cyc[4]), 80'd1);
        checkOutput("load_bk_queue_empty", 80'(bk_q.size()), 80'd0);
        repeat (2) @(posedge clk_sys);
        #1;
        checkOutput("idle_after_load", 80'({busy, ld_ready}), 80'd0);

        // Save with sv_ready toggling every cycle.
        ts = 32'h89AB_CDEF;
        st = 48'h0000_0123_4567;
        sv_words = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123, 16'h0000};
        pushSave(5, 1);
        sv_ready = 1'b1;
        applyStimulus(1'b0, 1'b1);
        checkOutput("save_not_valid_in_snap", 80'(sv_valid), 80'd0);
        n = 0;
        while (exp_done != 0 && n < 40) begin
            @(posedge clk_sys); #1;
            sv_ready = ~sv_ready;
            if (n == 0) checkOutput("save_valid_two_cycles", 80'(sv_valid), 80'd1);
            n++;
        end
        if (exp_done != 0) begin
            checkOutput("save_toggle_done_timeout", 80'(exp_done), 80'd0);
            exp_done = 0;
        end
        checkOutput("save_sv_queue_empty", 80'(sv_q.size()), 80'd0);

        // Timestamp keeps moving during SAVE; the stream must show the snapshot.
        ts = 32'h0001_FFFE;
        st = 48'hABCD_0000_1234;
        sv_words = '{16'hFFFE, 16'h0001, 16'h1234, 16'h0000, 16'hABCD};
        pushSave(5, 1);
        sv_ready = 1'b1;
        req_cyc  = cyc;
        applyStimulus(1'b0, 1'b1);
        n = 0;
        while (exp_done != 0 && n < 30) begin
            @(posedge clk_sys); #1;
            ts = ts + 32'd1;
            n++;
        end
        if (exp_done != 0) begin
            checkOutput("save_snap_done_timeout", 80'(exp_done), 80'd0);
            exp_done = 0;
        end
        checkOutput("save_latency", 80'(last_done_cyc - req_cyc), 80'd8);

        // Mapper without an RTC saves all-zero words.
        inuse = 1'b0;
        sv_words = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        pushSave(5, 1);
        applyStimulus(1'b0, 1'b1);
        waitDone("save_noinuse_done_timeout", 20);
        inuse = 1'b1;

        // Simultaneous requests: load with commit first, then the save.
        ld_words = '{16'h1010, 16'h2020, 16'h3030, 16'h4040, 16'h5050};
        pushLoad(5, 1);
        ts = 32'h1234_5678;
        st = 48'h9ABC_DEF0_1357;
        sv_words = '{16'h5678, 16'h1234, 16'h1357, 16'hDEF0, 16'h9ABC};
        pushSave(5, 1);
        sv_ready = 1'b1;
        ld_valid = 1'b1;
        ld_data  = ld_words[0];
        applyStimulus(1'b1, 1'b1);
        loadWords(5);
        waitDone("both_done_timeout", 40);
        checkOutput("save_after_commit", 80'(sv_cyc[0] > bk_cyc[5]), 80'd1);
        checkOutput("both_queues_empty", 80'(bk_q.size() + sv_q.size()), 80'd0);

        // Load stalls after word 2 until the timeout fires.
        ld_words = '{16'h0A00, 16'h0A01, 16'h0A02, 16'h0000, 16'h0000};
        pushLoad(3, 0);
        ld_valid = 1'b1;
        ld_data  = ld_words[0];
        applyStimulus(1'b1, 1'b0);
        loadWords(3);
        n = 0;
        while (!err && n < 200) begin
            @(posedge clk_sys); #1;
            n++;
        end
        checkOutput("timeout_err", 80'(err), 80'd1);
        checkOutput("timeout_stall_len", 80'(cyc - last_hs_cyc), 80'((1 << TB_TW) + 1));
        checkOutput("timeout_idle", 80'({busy, ld_ready}), 80'd0);
        repeat (4) @(posedge clk_sys);
        #1;
        checkOutput("timeout_no_commit", 80'(bk_q.size()), 80'd0);
        checkOutput("timeout_err_sticky", 80'(err), 80'd1);

        // Next accepted load clears err.
        ld_words = '{16'h0B00, 16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04};
        pushLoad(5, 1);
        ld_valid = 1'b1;
        ld_data  = ld_words[0];
        applyStimulus(1'b1, 1'b0);
        checkOutput("err_cleared", 80'(err), 80'd0);
        loadWords(5);
        waitDone("reload_done_timeout", 20);

        // Drop enable at save word 3 with a load pending.
        ts = 32'hFACE_B00C;
        st = 48'h0000_0000_0042;
        sv_words = '{16'hB00C, 16'hFACE, 16'h0042, 16'h0000, 16'h0000};
        pushSave(3, 0);
        sv_ready = 1'b1;
        applyStimulus(1'b0, 1'b1);
        n = 0;
        while (!(sv_valid && sv_addr == 3'd2) && n < 10) begin
            @(posedge clk_sys); #1;
            n++;
        end
        load_req = 1'b1;
        @(posedge clk_sys); #1;
        load_req = 1'b0;
        checkOutput("abort_at_word3", 80'(sv_addr), 80'd3);
        sv_ready = 1'b0;
        enable   = 1'b0;
        @(posedge clk_sys); #1;
        checkOutput("abort_outputs", 80'({sv_valid, ld_ready, bk_rtc_wr, done, busy}), 80'd0);
        enable = 1'b1;
        repeat (5) @(posedge clk_sys);
        #1;
        checkOutput("abort_pending_cleared", 80'({busy, ld_ready, sv_valid}), 80'd0);
        checkOutput("abort_sv_queue_empty", 80'(sv_q.size()), 80'd0);

        // Assert reset mid-load with a save pending.
        ld_words = '{16'hAAAA, 16'hBBBB, 16'h0000, 16'h0000, 16'h0000};
        pushLoad(1, 0);
        ld_valid = 1'b1;
        ld_data  = ld_words[0];
        applyStimulus(1'b1, 1'b0);
        save_req = 1'b1;
        @(posedge clk_sys); #1;
        save_req = 1'b0;
        ld_data  = ld_words[1];
        @(posedge clk_sys); #2;
        reset_n = 1'b0;
        #1;
        checkOutput("reset_mid_load_outputs",
            80'({ld_ready, sv_valid, sv_addr, sv_data, bk_rtc_wr, bk_addr, bk_data, busy, done, err}), 80'd0);
        ld_valid = 1'b0;
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk_sys);
        #1;
        checkOutput("reset_pending_cleared", 80'({busy, ld_ready, sv_valid}), 80'd0);
        checkOutput("final_queues_empty", 80'(bk_q.size() + sv_q.size() + exp_done), 80'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rtc_save_io.md
# rtc_save_io

Save-file sequencer for the cartridge RTC state used by the HuC3 mapper. On load it replays the five RTC words from the save-file bridge into the mapper's backup-write port (`bk_rtc_wr`/`bk_addr`/`bk_data`), then issues the commit write. On save it atomically snapshots `RTC_timestampOut`/`RTC_savedtimeOut` and streams the same five words back to the bridge. It sits between the save-file bridge and the mapper's RTC port.

## Interface
Parameters:
- `TIMEOUT_W`, 16: width of the load-stall timeout counter; a stall lasts 2^TIMEOUT_W cycles.

Ports:
- `clk_sys`  in  1  system clock.
- `reset_n`  in  1  reset; asynchronous assert, active-low.
- `enable`  in  1  RTC cartridge present; low = abort to IDLE.
- `load_req`  in  1  pulse: start load replay.
- `save_req`  in  1  pulse: start save stream.
- `ld_data`  in  16  load word from the bridge.
- `ld_valid`  in  1  `ld_data` is valid.
- `ld_ready`  out  1  block accepts a load word.
- `sv_data`  out  16  save word.
- `sv_addr`  out  3  save word index, 0..4.
- `sv_valid`  out  1  save word is valid.
- `sv_ready`  in  1  bridge accepts the save word.
- `RTC_timestampOut`  in  32  mapper timestamp.
- `RTC_savedtimeOut`  in  48  mapper packed {days, minutes, seconds}.
- `RTC_inuse`  in  1  mapper has an RTC.
- `bk_rtc_wr`  out  1  one-cycle write strobe to the mapper.
- `bk_addr`  out  17  word index; bits [16:3] are always 0.
- `bk_data`  out  16  write data.
- `busy`  out  1  not in IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  sticky load-timeout flag; cleared by the next `load_req` that is accepted.

## Operation
- States: IDLE, LOAD, COMMIT, SNAP, SAVE, FINISH.
- Word order for both directions:
  - 0 = ts[15:0]
  - 1 = ts[31:16]
  - 2 = st[15:0]
  - 3 = st[31:16]
  - 4 = st[47:32]
- IDLE:
  - Pending load → LOAD, word counter = 0, `err` cleared.
  - Otherwise pending save → SNAP.
  - Load has priority when both are pending.
- Pending bits:
  - One per request type; set by a request pulse in any state.
  - Cleared when that request is started.
  - A duplicate pulse while already pending is absorbed.
- LOAD:
  - `ld_ready` = 1.
  - On each `ld_valid & ld_ready`: the word is registered and the counter increments.
  - After word 4 → COMMIT.
  - The timeout counter restarts on each accepted word. If it expires, set `err`, go to IDLE, issue no commit and no `done`.
- COMMIT: one cycle; drives `bk_rtc_wr`=1, `bk_addr`=5, `bk_data`=0; then → FINISH.
- SNAP: one cycle.
  - Registers an 80-bit shadow {`RTC_savedtimeOut`, `RTC_timestampOut`}.
  - The shadow is all-zero if `RTC_inuse`=0.
  - → SAVE with counter = 0.
- SAVE:
  - `sv_valid` = 1; `sv_addr` = counter; `sv_data` = shadow word[counter].
  - `sv_data` and `sv_addr` are held stable while `sv_valid & ~sv_ready`.
  - On handshake the counter increments; after word 4 → FINISH.
- FINISH: `done` = 1 for one cycle, → IDLE.
- `enable` = 0 in any state:
  - Next state is IDLE.
  - Pending bits, counter and shadow are cleared.
  - All strobes are deasserted the same cycle; `err` is held.
- Counter is 3 bits. It never exceeds 4 in LOAD or SAVE; 5 is used only as the COMMIT address constant.

## Timing
- Reset values: all outputs 0; state IDLE; pending bits, counter, shadow and timeout are 0.
- Request to activity:
  - A `load_req` pulse in IDLE gives `ld_ready`=1 on the next cycle.
  - A `save_req` pulse gives `sv_valid`=1 two cycles later (IDLE → SNAP → SAVE).
- Load handshake → `bk_rtc_wr` with that word's index and data on the following cycle (registered).
  - Back-to-back handshakes give back-to-back strobes.
- COMMIT strobe: exactly one cycle after the strobe for word 4, never in the same cycle.
- `done`: one cycle after the COMMIT strobe, or one cycle after the word-4 save handshake.
- `busy`: high from the cycle after the request is sampled until the cycle after `done` or abort.
- Minimum latencies:
  - Full load with continuous `ld_valid`: 8 cycles from request to `done`.
  - Full save with continuous `sv_ready`: 8 cycles.
- A `save_req` during LOAD runs immediately after FINISH; the snapshot therefore reflects the just-loaded state only as far as the mapper has applied it.

## Structure
- Shared package `rtc_save_pkg`:
  - state enum;
  - `RTC_WORDS` = 5;
  - `RTC_COMMIT_ADDR` = 5;
  - `RTC_WORD_W` = 16;
  - the word-index-to-field mapping function used by both this block and the bridge.
- No sub-module: this is a single FSM with a shared counter, shadow register and timeout counter.

## Test plan
- Load words 0x1111, 0x2222, 0x3333, 0x4444, 0x0005 with continuous valid → strobes at addresses 0..4 carrying those data on consecutive cycles, then addr 5/data 0, then `done`; total 8 cycles.
- Save with ts=0x89ABCDEF, st=0x0000_0123_4567 and `sv_ready` toggling every other cycle → words 0xCDEF, 0x89AB, 0x4567, 0x0123, 0x0000 at `sv_addr` 0..4, each stable while stalled.
- `RTC_timestampOut` increments during SAVE → streamed words still equal the SNAP-cycle snapshot.
- `load_req` and `save_req` in the same cycle → full load (including commit) completes, then the save stream starts; one `done` per operation.
- Load stalls after word 2 for 2^TIMEOUT_W cycles → `err`=1, no addr-5 strobe, no `done`, IDLE; the next `load_req` clears `err`.
- `enable` dropped mid-SAVE at word 3, and separately `reset_n` asserted mid-LOAD → outputs 0 immediately (reset) or the next cycle (enable); IDLE; pending requests cleared.
